rom_load_seq: RTL and testbench
===============================

ROM_LOAD_SEQ -- requirements
Module: rom_load_seq

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, sets the number of write-buffer entries; it SHALL be a power of two, 2..16.
REQ-002 Parameter HOLD_CYCLES, default 64, sets the number of clk_sys cycles core_reset is held after the buffer drains.
REQ-003 Parameter ROM_LIMIT, default 17'h1_0000, sets the first download address that is out of range.
REQ-004 clk_sys  in  1  system clock (36 MHz); the single clock for all logic.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 ioctl_download  in  1  HPS download active.
REQ-007 ioctl_wr  in  1  one-cycle byte-write strobe from HPS.
REQ-008 ioctl_addr  in  25  HPS byte address.
REQ-009 ioctl_dout  in  8  HPS byte data.
REQ-010 dn_ready  in  1  game core accepts a write this cycle.
REQ-011 dn_addr  out  17  core write address.
REQ-012 dn_data  out  8  core write data.
REQ-013 dn_wr  out  1  core write strobe.
REQ-014 core_reset  out  1  reset to the game core.
REQ-015 load_done  out  1  at least one download has completed since reset.
REQ-016 overflow  out  1  sticky error: a byte was dropped.
REQ-017 byte_count  out  17  bytes forwarded in the current or last download, saturating.

Function
REQ-018 The block SHALL have five states: IDLE, LOAD, DRAIN, HOLD and RUN.
REQ-019 IDLE SHALL go to HOLD on the first cycle after reset deasserts.
REQ-020 In any state, a rising edge of ioctl_download SHALL enter LOAD, clear byte_count and clear the hold counter.
REQ-021 In LOAD, each ioctl_wr with ioctl_addr < ROM_LIMIT and the FIFO not full SHALL push {addr[16:0], data} in the same cycle.
REQ-022 An ioctl_wr with ioctl_addr >= ROM_LIMIT, or with the FIFO full, SHALL be dropped and SHALL set overflow.
REQ-023 An ioctl_wr outside LOAD SHALL be ignored and SHALL NOT set overflow.
REQ-024 When the FIFO is non-empty and dn_ready=1, the block SHALL pop one entry, present it on dn_addr/dn_data and assert dn_wr for exactly that cycle.
REQ-025 Push to pop latency SHALL be one cycle minimum: an entry pushed in cycle N SHALL be eligible to appear on dn_wr in cycle N+1.
REQ-026 A push and a pop in the same cycle SHALL both occur, and the occupancy SHALL stay unchanged.
REQ-027 dn_addr/dn_data SHALL hold their last values while dn_wr=0.
REQ-028 byte_count SHALL increment on each pop and saturate at 17'h1FFFF.
REQ-029 A falling edge of ioctl_download in LOAD SHALL go to DRAIN; DRAIN SHALL go to HOLD on the cycle the FIFO becomes empty.
REQ-030 HOLD SHALL count HOLD_CYCLES cycles and then go to RUN; leaving DRAIN SHALL set load_done.
REQ-031 core_reset SHALL be 1 in IDLE, LOAD, DRAIN and HOLD, and 0 only in RUN.
REQ-032 The FIFO pointers SHALL wrap modulo FIFO_DEPTH; full and empty SHALL be distinguished by an extra pointer bit.

Reset
REQ-033 Reset SHALL force state=IDLE, FIFO empty, dn_wr=0, dn_addr=0, dn_data=0, core_reset=1, load_done=0, overflow=0 and byte_count=0.
REQ-034 Reset asserted mid-download SHALL discard all buffered entries, and no dn_wr SHALL follow reset release until a new LOAD.
REQ-035 The ioctl_download edge detector SHALL reset to 0, so a download already high at reset release SHALL register as a rising edge.

Structure
REQ-036 The state enumeration, ROM_LIMIT default and HOLD_CYCLES default SHALL live in the shared core package.
REQ-037 The write buffer SHALL be one sub-module, rom_load_fifo, parameterised by depth and width (25 bits), with push, pop, full and empty.

Verification
REQ-038 Reset released with download low -> core_reset=1 for exactly 1+64 cycles, then 0; dn_wr never asserted.
REQ-039 Download of 16 bytes at 0x0000-0x000F with dn_ready=1 -> 16 dn_wr pulses in order, byte_count=16, load_done=1, core_reset falls 64 cycles after the last write.
REQ-040 dn_ready=0 while 5 back-to-back writes arrive -> 4 buffered, 5th dropped, overflow=1; raising dn_ready drains 4 entries in 4 cycles.
REQ-041 Write to 0x10000 -> dropped, overflow=1, byte_count unchanged.
REQ-042 Download re-raised 10 cycles into HOLD -> state LOAD, core_reset stays 1, byte_count=0.
REQ-043 Reset asserted with 3 entries buffered -> dn_wr=0 immediately, FIFO empty, overflow=0 after release.

Source files
------------

// File: rtl/rom_load_seq_pkg.sv
// rom_load_seq_pkg: shared state encoding and defaults for the ROM download sequencer.
package rom_load_seq_pkg;
  typedef enum logic [2:0] {ST_IDLE, ST_LOAD, ST_DRAIN, ST_HOLD, ST_RUN} state_t;
  localparam logic [16:0] ROM_LIMIT_DEF = 17'h1_0000;
  localparam int HOLD_CYCLES_DEF = 64;
  localparam int ENTRY_W = 25;
endpackage

// File: rtl/rom_load_fifo.sv
// rom_load_fifo: write buffer with extra-bit pointers so full and empty stay distinct.
module rom_load_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 25
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty,
  output logic             o_last
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0]      r_wr_ptr, r_rd_ptr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      w_count;
  assign w_count = r_wr_ptr - r_rd_ptr;
  assign o_empty = r_wr_ptr == r_rd_ptr;
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_last  = w_count == (AW+1)'(1);
  assign o_data  = r_mem[r_rd_ptr[AW-1:0]];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end
endmodule

// File: rtl/rom_load_seq.sv
// rom_load_seq: buffers HPS ROM download bytes into the core and sequences core reset.
module rom_load_seq
  import rom_load_seq_pkg::*;
#(
  parameter int          FIFO_DEPTH  = 4,
  parameter int          HOLD_CYCLES = HOLD_CYCLES_DEF,
  parameter logic [16:0] ROM_LIMIT   = ROM_LIMIT_DEF
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  input  logic        dn_ready,
  output logic [16:0] dn_addr,
  output logic [7:0]  dn_data,
  output logic        dn_wr,
  output logic        core_reset,
  output logic        load_done,
  output logic        overflow,
  output logic [16:0] byte_count
);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  state_t       r_state;
  logic         r_dl, r_dn_wr, r_core_reset, r_load_done, r_overflow;
  logic [16:0]  r_dn_addr, r_byte_count;
  logic [7:0]   r_dn_data;
  logic [HW-1:0] r_hold;
  logic         w_rise, w_fall, w_wr_load, w_push, w_pop, w_full, w_empty, w_last;
  logic [ENTRY_W-1:0] w_head;
  assign w_rise    = ioctl_download & ~r_dl;
  assign w_fall    = ~ioctl_download & r_dl;
  assign w_wr_load = (r_state == ST_LOAD) & ioctl_wr;
  assign w_push    = w_wr_load & (ioctl_addr < {8'd0, ROM_LIMIT}) & ~w_full;
  assign w_pop     = ~w_empty & dn_ready;
  rom_load_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(ENTRY_W)) u_fifo (
    .clk     (clk_sys),
    .rst     (reset),
    .i_push  (w_push),
    .i_data  ({ioctl_addr[16:0], ioctl_dout}),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_last  (w_last)
  );
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_dl         <= 1'b0;
      r_hold       <= '0;
      r_dn_wr      <= 1'b0;
      r_dn_addr    <= '0;
      r_dn_data    <= '0;
      r_core_reset <= 1'b1;
      r_load_done  <= 1'b0;
      r_overflow   <= 1'b0;
      r_byte_count <= '0;
    end else begin
      r_dl    <= ioctl_download;
      r_dn_wr <= w_pop;
      if (w_pop) {r_dn_addr, r_dn_data} <= w_head;
      if (w_wr_load & ~w_push) r_overflow <= 1'b1;
      // a new download restarts the sequence from any state
      if (w_rise) begin
        r_state      <= ST_LOAD;
        r_hold       <= '0;
        r_byte_count <= '0;
        r_core_reset <= 1'b1;
      end else begin
        if (w_pop && r_byte_count != 17'h1FFFF) r_byte_count <= r_byte_count + 17'd1;
        case (r_state)
          ST_IDLE: r_state <= ST_HOLD;
          ST_LOAD: if (w_fall) r_state <= ST_DRAIN;
          ST_DRAIN: if (w_empty | (w_pop & w_last)) begin
            r_state     <= ST_HOLD;
            r_hold      <= '0;
            r_load_done <= 1'b1;
          end
          ST_HOLD: if (r_hold == HW'(HOLD_CYCLES - 1)) begin
            r_state      <= ST_RUN;
            r_core_reset <= 1'b0;
          end else r_hold <= r_hold + 1'b1;
          ST_RUN: r_state <= ST_RUN;
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end
  assign dn_addr    = r_dn_addr;
  assign dn_data    = r_dn_data;
  assign dn_wr      = r_dn_wr;
  assign core_reset = r_core_reset;
  assign load_done  = r_load_done;
  assign overflow   = r_overflow;
  assign byte_count = r_byte_count;
endmodule

// File: tb/tb_rom_load_seq.sv
// tb_rom_load_seq: directed sequences, a vector table and a queue-model random run.
module tb_rom_load_seq;
  logic        clk_sys = 1'b0, reset = 1'b1;
  logic        ioctl_download = 1'b0, ioctl_wr = 1'b0, dn_ready = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0]  ioctl_dout = '0;
  logic [16:0] dn_addr, byte_count;
  logic [7:0]  dn_data;
  logic        dn_wr, core_reset, load_done, overflow;

  rom_load_seq dut (
    .clk_sys(clk_sys), .reset(reset), .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .dn_ready(dn_ready), .dn_addr(dn_addr),
    .dn_data(dn_data), .dn_wr(dn_wr), .core_reset(core_reset), .load_done(load_done),
    .overflow(overflow), .byte_count(byte_count)
  );

  always #5 clk_sys = ~clk_sys;

  int cyc = 0;
  always @(posedge clk_sys) cyc <= cyc + 1;

  logic [24:0] cap[$];
  int          cap_cyc[$];
  always @(negedge clk_sys) if (dn_wr === 1'b1) begin
    cap.push_back({dn_addr, dn_data});
    cap_cyc.push_back(cyc);
  end

  int n_cmp = 0, n_bad = 0;

  typedef struct {
    logic [24:0] addr;
    logic [7:0]  data;
    int          fwd;
    logic        ovf;
    int          bc;
  } vec_t;
  vec_t tbl[6];

  logic [24:0] q[$];
  logic [24:0] last_val;
  int          model_bc;
  logic        model_ovf;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk_sys);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wr_byte(input logic [24:0] a, input logic [7:0] d);
    ioctl_wr = 1'b1;
    ioctl_addr = a;
    ioctl_dout = d;
    tick();
    ioctl_wr = 1'b0;
  endtask

  task automatic wait_run(output int at);
    for (int i = 0; i < 300 && core_reset; i++) tick();
    at = cyc;
  endtask

  // reference: depth-4 queue; pop if non-empty and ready, push if in range and not full before the edge
  task automatic step_model();
    int  pre;
    logic exp_pop, push_ok;
    pre = q.size();
    exp_pop = (pre > 0) && dn_ready;
    push_ok = ioctl_wr && (ioctl_addr < 25'h10000) && (pre < 4);
    tick();
    check("rnd_wr", {31'd0, dn_wr}, {31'd0, exp_pop});
    if (exp_pop) begin
      last_val = q.pop_front();
      model_bc++;
    end
    check("rnd_out", {7'd0, dn_addr, dn_data}, {7'd0, last_val});
    if (push_ok) q.push_back({ioctl_addr[16:0], ioctl_dout});
    if (ioctl_wr && !push_ok) model_ovf = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int at, t0;
    tbl[0] = '{25'h0000000, 8'hA5, 1, 1'b0, 1};
    tbl[1] = '{25'h000FFFF, 8'h5A, 1, 1'b0, 2};
    tbl[2] = '{25'h0010000, 8'h11, 0, 1'b1, 2};
    tbl[3] = '{25'h1FFFFFF, 8'h22, 0, 1'b1, 2};
    tbl[4] = '{25'h0001234, 8'h33, 1, 1'b1, 3};
    tbl[5] = '{25'h000ABCD, 8'hC3, 1, 1'b1, 4};

    tick(3);
    check("rst_dn_wr", {31'd0, dn_wr}, 0);
    check("rst_dn_addr", {15'd0, dn_addr}, 0);
    check("rst_dn_data", {24'd0, dn_data}, 0);
    check("rst_core_reset", {31'd0, core_reset}, 1);
    check("rst_load_done", {31'd0, load_done}, 0);
    check("rst_overflow", {31'd0, overflow}, 0);
    check("rst_byte_count", {15'd0, byte_count}, 0);

    reset = 1'b0;
    t0 = cyc;
    wait_run(at);
    check("boot_hold_len", at - t0, 65);
    check("boot_no_wr", cap.size(), 0);

    // 16-byte download, download drops together with the last write
    dn_ready = 1'b1;
    ioctl_download = 1'b1;
    tick();
    cap.delete(); cap_cyc.delete();
    for (int i = 0; i < 16; i++) begin
      if (i == 15) ioctl_download = 1'b0;
      wr_byte(25'(i), 8'(8'h30 + i));
    end
    wait_run(at);
    check("dl16_count", cap.size(), 16);
    for (int i = 0; i < 16 && i < cap.size(); i++)
      check("dl16_entry", {7'd0, cap[i]}, {7'd0, 17'(i), 8'(8'h30 + i)});
    check("dl16_bc", {15'd0, byte_count}, 16);
    check("dl16_done", {31'd0, load_done}, 1);
    if (cap.size() > 0) check("dl16_release_gap", at - cap_cyc[cap.size()-1], 64);

    // buffer fills while the core stalls
    ioctl_download = 1'b1;
    tick(2);
    dn_ready = 1'b0;
    cap.delete(); cap_cyc.delete();
    for (int i = 0; i < 5; i++) wr_byte(25'h100 + 25'(i), 8'(8'h50 + i));
    tick();
    check("full_ovf", {31'd0, overflow}, 1);
    check("full_stalled", cap.size(), 0);
    dn_ready = 1'b1;
    tick(6);
    check("full_drain_count", cap.size(), 4);
    for (int i = 0; i < 4 && i < cap.size(); i++)
      check("full_entry", {7'd0, cap[i]}, {7'd0, 17'h100 + 17'(i), 8'(8'h50 + i)});
    if (cap.size() == 4) check("full_drain_span", cap_cyc[3] - cap_cyc[0], 3);

    // reset with entries buffered while download stays high
    dn_ready = 1'b0;
    for (int i = 0; i < 3; i++) wr_byte(25'h200 + 25'(i), 8'(8'h70 + i));
    dn_ready = 1'b1;
    tick();
    check("mid_pre_wr", {31'd0, dn_wr}, 1);
    #2 reset = 1'b1;
    #1;
    check("mid_dn_wr", {31'd0, dn_wr}, 0);
    check("mid_ovf", {31'd0, overflow}, 0);
    check("mid_core_reset", {31'd0, core_reset}, 1);
    check("mid_bc", {15'd0, byte_count}, 0);
    check("mid_done", {31'd0, load_done}, 0);
    tick(2);
    reset = 1'b0;
    cap.delete(); cap_cyc.delete();
    tick(20);
    check("mid_no_wr", cap.size(), 0);
    check("mid_in_load", {31'd0, core_reset}, 1);

    foreach (tbl[i]) begin
      cap.delete(); cap_cyc.delete();
      wr_byte(tbl[i].addr, tbl[i].data);
      tick(3);
      check("tbl_fwd", cap.size(), tbl[i].fwd);
      if (tbl[i].fwd == 1 && cap.size() > 0)
        check("tbl_entry", {7'd0, cap[0]}, {7'd0, tbl[i].addr[16:0], tbl[i].data});
      check("tbl_ovf", {31'd0, overflow}, {31'd0, tbl[i].ovf});
      check("tbl_bc", {15'd0, byte_count}, tbl[i].bc);
    end

    model_bc = 4;
    model_ovf = 1'b1;
    last_val = {17'h0ABCD, 8'hC3};
    for (int k = 0; k < 400; k++) begin
      dn_ready = ($urandom_range(0, 3) != 0);
      ioctl_wr = 1'($urandom_range(0, 1));
      ioctl_addr = ($urandom_range(0, 7) == 0) ? 25'(32'h10000 + $urandom_range(0, 20))
                                               : 25'($urandom_range(0, 16'hFFFF));
      ioctl_dout = 8'($urandom);
      step_model();
    end
    ioctl_wr = 1'b0;
    dn_ready = 1'b1;
    for (int k = 0; k < 8; k++) step_model();
    check("rnd_bc", {15'd0, byte_count}, model_bc);
    check("rnd_ovf", {31'd0, overflow}, {31'd0, model_ovf});
    check("rnd_empty", q.size(), 0);
    ioctl_download = 1'b0;
    wait_run(at);
    check("rnd_run", {31'd0, core_reset}, 0);
    check("rnd_done", {31'd0, load_done}, 1);

    // download re-raised partway through HOLD
    ioctl_download = 1'b1;
    tick(2);
    wr_byte(25'h42, 8'h99);
    ioctl_download = 1'b0;
    tick(2);
    tick(10);
    check("rehold_core_reset", {31'd0, core_reset}, 1);
    check("rehold_bc_pre", {15'd0, byte_count}, 1);
    ioctl_download = 1'b1;
    tick();
    check("rehold_core_reset2", {31'd0, core_reset}, 1);
    check("rehold_bc", {15'd0, byte_count}, 0);
    tick(80);
    check("rehold_stays_load", {31'd0, core_reset}, 1);
    cap.delete(); cap_cyc.delete();
    wr_byte(25'h77, 8'hEE);
    tick(3);
    check("rehold_fwd", cap.size(), 1);
    if (cap.size() > 0) check("rehold_entry", {7'd0, cap[0]}, {7'd0, 17'h77, 8'hEE});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
